// File: rtl/intersection_phase_arbiter.sv
// Four-way right-of-way arbiter (roads A/B/C plus pedestrian) with green/yellow/all-red sequencing.
// Define EMERGENCY_PREEMPT_EN to add the EMG/EMG_DIR preemption inputs.
module intersection_phase_arbiter #(
    parameter int TICK_DIV  = 1000,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       HOLD,
    input  logic       REQ_A,
    input  logic       REQ_B,
    input  logic       REQ_C,
    input  logic       PED_BTN,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic       EMG,
    input  logic [1:0] EMG_DIR,
`endif
    output logic       GA,
    output logic       YA,
    output logic       RA,
    output logic       GB,
    output logic       YB,
    output logic       RB,
    output logic       GC,
    output logic       YC,
    output logic       RC,
    output logic       WALK,
    output logic       DONTWALK,
    output logic       PED_ACK,
    output logic [2:0] PHASE,
    output logic [4:0] TIMER
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        PH_ALLRED = 3'd0, PH_GRN_A = 3'd1, PH_YEL_A = 3'd2, PH_GRN_B = 3'd3,
        PH_YEL_B  = 3'd4, PH_GRN_C = 3'd5, PH_YEL_C = 3'd6, PH_WALK  = 3'd7
    } phase_e;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [4:0]    GMIN_LAST   = 5'(GREEN_MIN - 1);
    localparam logic [4:0]    GMAX_LAST   = 5'(GREEN_MAX - 1);
    localparam logic [4:0]    YELLOW_LAST = 5'(YELLOW_T - 1);
    localparam logic [4:0]    ALLRED_LAST = 5'(ALLRED_T - 1);
    localparam logic [4:0]    WALK_LAST   = 5'(WALK_T - 1);
    // {GA,YA,RA,GB,YB,RB,GC,YC,RC,WALK,DONTWALK} for all-red
    localparam logic [10:0]   LAMPS_RST   = 11'b001_001_001_01;

    phase_e        phase_q, phase_d;
    logic [4:0]    timer_q, timer_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    owner_q, owner_d;
    logic [3:0]    pend_q, pend_d;
    logic [10:0]   lamps_q, lamps_d;
    logic          tick, others, found;
    logic [3:0]    req, serving;
    logic [1:0]    cur, cand, pick;
`ifdef EMERGENCY_PREEMPT_EN
    logic [1:0]    emg_dir;
`endif

    function automatic logic [10:0] decode(input phase_e ph);
        logic ga, ya, gb, yb, gc, yc, wk;
        ga = (ph == PH_GRN_A);
        ya = (ph == PH_YEL_A);
        gb = (ph == PH_GRN_B);
        yb = (ph == PH_YEL_B);
        gc = (ph == PH_GRN_C);
        yc = (ph == PH_YEL_C);
        wk = (ph == PH_WALK);
        return {ga, ya, !(ga || ya), gb, yb, !(gb || yb), gc, yc, !(gc || yc), wk, !wk};
    endfunction

    always_comb begin
        // Requester index 0..3 = A,B,C,P; green/walk phases are {index,1}
        req     = {PED_BTN, REQ_C, REQ_B, REQ_A};
        cur     = phase_q[2:1];
        serving = '0;
        if (phase_q[0]) serving[cur] = 1'b1;
        others  = |(pend_q & ~serving);

        presc_d = presc_q;
        tick    = 1'b0;
        if (!HOLD) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        pick  = 2'd0;
        found = 1'b0;
        cand  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = owner_q + 2'(k);
            if (!found && pend_q[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end

`ifdef EMERGENCY_PREEMPT_EN
        emg_dir = (EMG_DIR == 2'd3) ? 2'd0 : EMG_DIR;
`endif

        phase_d = phase_q;
        owner_d = owner_q;
        if (tick) begin
            case (phase_q)
                PH_ALLRED: if (timer_q == ALLRED_LAST) begin
                    phase_d = phase_e'({pick, 1'b1});
                    owner_d = pick;
                end
                PH_GRN_A, PH_GRN_B, PH_GRN_C:
                    if (others && ((timer_q >= GMIN_LAST && !req[cur]) || timer_q >= GMAX_LAST))
                        phase_d = phase_e'(phase_q + 3'd1);
                PH_WALK: if (timer_q == WALK_LAST) phase_d = PH_ALLRED;
                default: if (timer_q == YELLOW_LAST) phase_d = PH_ALLRED;
            endcase
`ifdef EMERGENCY_PREEMPT_EN
            if (EMG) begin
                case (phase_q)
                    PH_ALLRED: if (timer_q == ALLRED_LAST) begin
                        phase_d = phase_e'({emg_dir, 1'b1});
                        owner_d = emg_dir;
                    end
                    PH_GRN_A, PH_GRN_B, PH_GRN_C:
                        phase_d = (cur == emg_dir) ? phase_q : phase_e'(phase_q + 3'd1);
                    PH_WALK: phase_d = PH_ALLRED;
                    default: ;
                endcase
            end
`endif
        end

        timer_d = timer_q;
        if (tick) begin
            if (phase_d != phase_q) timer_d = '0;
            else if (timer_q != 5'd31) timer_d = timer_q + 5'd1;
        end

        // Entering a green/walk clears that requester even if it is requesting this cycle
        pend_d = pend_q | (req & ~serving);
        if (phase_d != phase_q && phase_d[0]) pend_d[phase_d[2:1]] = 1'b0;

        lamps_d = decode(phase_d);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            phase_q <= PH_ALLRED;
            timer_q <= '0;
            presc_q <= '0;
            owner_q <= 2'd3;
            pend_q  <= '0;
            lamps_q <= LAMPS_RST;
        end else begin
            phase_q <= phase_d;
            timer_q <= timer_d;
            presc_q <= presc_d;
            owner_q <= owner_d;
            pend_q  <= pend_d;
            lamps_q <= lamps_d;
        end
    end

    assign {GA, YA, RA, GB, YB, RB, GC, YC, RC, WALK, DONTWALK} = lamps_q;
    assign PED_ACK = pend_q[3];
    assign PHASE   = phase_q;
    assign TIMER   = timer_q;
endmodule
